// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S processor: instruction decode
// enumeration, opcode values and ALU operation selects.
package k_and_s_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int RIDX_W = 2;

    typedef enum logic [3:0] {
        I_NOP,
        I_BRANCH,
        I_BZERO,
        I_BNZERO,
        I_BNEG,
        I_BNNEG,
        I_BOV,
        I_BNOV,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_HALT
    } decoded_instruction_type;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_BRANCH = 8'h01;
    localparam logic [7:0] OP_BZERO  = 8'h02;
    localparam logic [7:0] OP_BNZERO = 8'h03;
    localparam logic [7:0] OP_BNEG   = 8'h04;
    localparam logic [7:0] OP_BNNEG  = 8'h05;
    localparam logic [7:0] OP_BOV    = 8'h06;
    localparam logic [7:0] OP_BNOV   = 8'h07;
    localparam logic [7:0] OP_LOAD   = 8'h81;
    localparam logic [7:0] OP_STORE  = 8'h82;
    localparam logic [7:0] OP_MOVE   = 8'h91;
    localparam logic [7:0] OP_ADD    = 8'hA1;
    localparam logic [7:0] OP_SUB    = 8'hA2;
    localparam logic [7:0] OP_AND    = 8'hA3;
    localparam logic [7:0] OP_OR     = 8'hA4;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    localparam logic [1:0] ALU_OR  = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

endpackage

// File: rtl/data_path_alu.sv
// Combinational 16-bit ALU with zero/negative/carry-borrow/signed-overflow
// status; the status is registered by the enclosing data_path.
module alu
    import k_and_s_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  operation,
    output logic [15:0] result,
    output logic        zero,
    output logic        neg,
    output logic        unsigned_overflow,
    output logic        signed_overflow
);

    logic [16:0] w_sum;
    logic [16:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result            = a | b;
        unsigned_overflow = 1'b0;
        signed_overflow   = 1'b0;
        case (operation)
            ALU_ADD: begin
                result            = w_sum[15:0];
                unsigned_overflow = w_sum[16];
                signed_overflow   = (a[15] == b[15]) && (w_sum[15] != a[15]);
            end
            ALU_SUB: begin
                result            = w_diff[15:0];
                // Bit 16 of the zero-extended difference is the borrow (a < b).
                unsigned_overflow = w_diff[16];
                signed_overflow   = (a[15] != b[15]) && (w_diff[15] != a[15]);
            end
            ALU_AND: result = a & b;
            default: result = a | b;
        endcase
    end

    assign zero = (result == 16'h0000);
    assign neg  = result[15];

endmodule

// File: rtl/data_path.sv
// K&S processor datapath: PC, IR, 4x16 register file, ALU and flag register.
// Every state change is gated by a strobe from control_unit.
module data_path
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [4:0]              ram_addr,
    input  logic [15:0]             data_in,
    output logic [15:0]             data_out
);

    logic [4:0]  r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_regs [4];

    logic [7:0]  w_opcode;
    logic [1:0]  w_a_idx;
    logic [1:0]  w_b_idx;
    logic [1:0]  w_c_idx;
    logic [15:0] w_a_val;
    logic [15:0] w_b_val;
    logic [15:0] w_wdata;
    logic [15:0] w_alu_result;
    logic        w_alu_zero;
    logic        w_alu_neg;
    logic        w_alu_uov;
    logic        w_alu_sov;
    logic        w_unused_ir7;

    assign w_opcode     = r_ir[15:8];
    assign w_unused_ir7 = r_ir[7];

    always_comb begin
        decoded_instruction = I_NOP;
        case (w_opcode)
            OP_BRANCH: decoded_instruction = I_BRANCH;
            OP_BZERO:  decoded_instruction = I_BZERO;
            OP_BNZERO: decoded_instruction = I_BNZERO;
            OP_BNEG:   decoded_instruction = I_BNEG;
            OP_BNNEG:  decoded_instruction = I_BNNEG;
            OP_BOV:    decoded_instruction = I_BOV;
            OP_BNOV:   decoded_instruction = I_BNOV;
            OP_LOAD:   decoded_instruction = I_LOAD;
            OP_STORE:  decoded_instruction = I_STORE;
            OP_MOVE:   decoded_instruction = I_MOVE;
            OP_ADD:    decoded_instruction = I_ADD;
            OP_SUB:    decoded_instruction = I_SUB;
            OP_AND:    decoded_instruction = I_AND;
            OP_OR:     decoded_instruction = I_OR;
            OP_HALT:   decoded_instruction = I_HALT;
            default:   decoded_instruction = I_NOP;
        endcase
    end

    // Register-op field layout is the default; LOAD/STORE and MOVE override it.
    always_comb begin
        w_c_idx = r_ir[5:4];
        w_a_idx = r_ir[3:2];
        w_b_idx = r_ir[1:0];
        case (decoded_instruction)
            I_LOAD, I_STORE: begin
                w_c_idx = r_ir[6:5];
                w_a_idx = r_ir[6:5];
            end
            I_MOVE: begin
                w_c_idx = r_ir[3:2];
                w_a_idx = r_ir[1:0];
                w_b_idx = r_ir[1:0];
            end
            default: ;
        endcase
    end

    assign w_a_val  = r_regs[w_a_idx];
    assign w_b_val  = r_regs[w_b_idx];
    assign data_out = w_a_val;
    assign w_wdata  = c_sel ? data_in : w_alu_result;
    assign ram_addr = addr_sel ? r_ir[4:0] : r_pc;

    alu u_alu (
        .a                 (w_a_val),
        .b                 (w_b_val),
        .operation         (operation),
        .result            (w_alu_result),
        .zero              (w_alu_zero),
        .neg               (w_alu_neg),
        .unsigned_overflow (w_alu_uov),
        .signed_overflow   (w_alu_sov)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
            r_ir <= '0;
        end else begin
            if (pc_enable)
                r_pc <= branch ? r_ir[4:0] : r_pc + 5'd1;
            if (ir_enable)
                r_ir <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++)
                r_regs[i] <= '0;
        end else if (write_reg_enable) begin
            r_regs[w_c_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= w_alu_zero;
            neg_op            <= w_alu_neg;
            unsigned_overflow <= w_alu_uov;
            signed_overflow   <= w_alu_sov;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Directed, table-driven bench for data_path: decode table, ALU/flag table
// and hand-written PC, fetch, MOVE and mid-instruction reset sequences.
module tb_data_path;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic branch, pc_enable, ir_enable, write_reg_enable;
    logic addr_sel, c_sel, flags_reg_enable;
    logic [1:0]  operation;
    logic [15:0] data_in;
    decoded_instruction_type decoded_instruction;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [4:0]  ram_addr;
    logic [15:0] data_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_path dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .write_reg_enable    (write_reg_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .flags_reg_enable    (flags_reg_enable),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_in             (data_in),
        .data_out            (data_out)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [7:0]  opc;
        logic [15:0] res;
        logic [3:0]  flags;   // {zero, neg, unsigned_ovf, signed_ovf}
    } alu_vec_t;

    typedef struct {
        logic [15:0]             ir;
        decoded_instruction_type dec;
    } dec_vec_t;

    alu_vec_t alu_tab[10];
    dec_vec_t dec_tab[19];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_strobes();
        branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
        addr_sel = 0; c_sel = 0; flags_reg_enable = 0; operation = 2'b00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ir(input logic [15:0] v);
        data_in   = v;
        ir_enable = 1;
        step();
        ir_enable = 0;
    endtask

    task automatic load_reg(input logic [1:0] idx, input logic [15:0] val);
        fetch_ir({8'h81, 1'b0, idx, 5'd0});
        data_in = val; c_sel = 1; write_reg_enable = 1;
        step();
        c_sel = 0; write_reg_enable = 0;
    endtask

    task automatic read_reg(input logic [1:0] idx, output logic [15:0] val);
        fetch_ir({8'h82, 1'b0, idx, 5'd0});
        val = data_out;
    endtask

    function automatic logic [3:0] flags_now();
        return {zero_op, neg_op, unsigned_overflow, signed_overflow};
    endfunction

    logic [15:0] rv;

    initial begin
        alu_tab[0] = '{16'h7FFF, 16'h0001, 2'b01, 8'hA1, 16'h8000, 4'b0101};
        alu_tab[1] = '{16'h0000, 16'h0001, 2'b10, 8'hA2, 16'hFFFF, 4'b0110};
        alu_tab[2] = '{16'hFFFF, 16'h0001, 2'b01, 8'hA1, 16'h0000, 4'b1010};
        alu_tab[3] = '{16'h8000, 16'h0001, 2'b10, 8'hA2, 16'h7FFF, 4'b0001};
        alu_tab[4] = '{16'hF0F0, 16'h0FF0, 2'b11, 8'hA3, 16'h00F0, 4'b0000};
        alu_tab[5] = '{16'hF000, 16'h000F, 2'b00, 8'hA4, 16'hF00F, 4'b0100};
        alu_tab[6] = '{16'h1234, 16'h1234, 2'b10, 8'hA2, 16'h0000, 4'b1000};
        alu_tab[7] = '{16'h00FF, 16'hFF00, 2'b11, 8'hA3, 16'h0000, 4'b1000};
        alu_tab[8] = '{16'h8000, 16'h8000, 2'b01, 8'hA1, 16'h0000, 4'b1011};
        alu_tab[9] = '{16'h0001, 16'h8000, 2'b10, 8'hA2, 16'h8001, 4'b0111};

        dec_tab[0]  = '{16'h0000, I_NOP};
        dec_tab[1]  = '{16'h0105, I_BRANCH};
        dec_tab[2]  = '{16'h0200, I_BZERO};
        dec_tab[3]  = '{16'h0300, I_BNZERO};
        dec_tab[4]  = '{16'h0400, I_BNEG};
        dec_tab[5]  = '{16'h0500, I_BNNEG};
        dec_tab[6]  = '{16'h0600, I_BOV};
        dec_tab[7]  = '{16'h0700, I_BNOV};
        dec_tab[8]  = '{16'h8125, I_LOAD};
        dec_tab[9]  = '{16'h8200, I_STORE};
        dec_tab[10] = '{16'h910D, I_MOVE};
        dec_tab[11] = '{16'hA100, I_ADD};
        dec_tab[12] = '{16'hA200, I_SUB};
        dec_tab[13] = '{16'hA300, I_AND};
        dec_tab[14] = '{16'hA400, I_OR};
        dec_tab[15] = '{16'hFF00, I_HALT};
        dec_tab[16] = '{16'h5512, I_NOP};
        dec_tab[17] = '{16'h0800, I_NOP};
        dec_tab[18] = '{16'hA500, I_NOP};

        clear_strobes();
        data_in = 16'h0000;
        rst_n   = 0;
        #1;
        check("reset_ram_addr_async", {11'd0, ram_addr}, 16'd0);
        step(); step();
        rst_n = 1;
        step();

        check("reset_ram_addr", {11'd0, ram_addr}, 16'd0);
        check("reset_decode", 16'(decoded_instruction), 16'(I_NOP));
        check("reset_flags", {12'd0, flags_now()}, 16'd0);
        check("reset_data_out", data_out, 16'h0000);

        // Fetch: IR captures data_in, PC increments from 0
        data_in = 16'h8125; ir_enable = 1; pc_enable = 1;
        step();
        clear_strobes();
        check("fetch_decode_load", 16'(decoded_instruction), 16'(I_LOAD));
        check("fetch_pc", {11'd0, ram_addr}, 16'd1);
        addr_sel = 1; #1;
        check("load_addr_field", {11'd0, ram_addr}, 16'd5);
        data_in = 16'hBEEF; c_sel = 1; write_reg_enable = 1; #1;
        check("read_before_write_old", data_out, 16'h0000);
        step();
        check("write_visible_next", data_out, 16'hBEEF);
        clear_strobes();
        data_in = 16'h1111; c_sel = 1; step();
        c_sel = 0;
        read_reg(2'd1, rv);
        check("csel_ignored_no_we", rv, 16'hBEEF);

        // ALU/flag table: R0 op R1 -> R2
        foreach (alu_tab[i]) begin
            load_reg(2'd0, alu_tab[i].a);
            load_reg(2'd1, alu_tab[i].b);
            fetch_ir({alu_tab[i].opc, 8'h21});
            operation = alu_tab[i].op; write_reg_enable = 1; flags_reg_enable = 1;
            step();
            clear_strobes();
            check($sformatf("alu%0d_flags", i), {12'd0, flags_now()}, {12'd0, alu_tab[i].flags});
            read_reg(2'd2, rv);
            check($sformatf("alu%0d_result", i), rv, alu_tab[i].res);
        end

        // Flags hold with flags_reg_enable low
        load_reg(2'd0, 16'h0001);
        load_reg(2'd1, 16'h0001);
        fetch_ir(16'hA121);
        operation = 2'b01; write_reg_enable = 1;
        step();
        clear_strobes();
        check("flags_hold", {12'd0, flags_now()}, 16'h0007);
        read_reg(2'd2, rv);
        check("add_no_flags_result", rv, 16'h0002);

        // PC branch and wrap
        fetch_ir(16'h001F);
        branch = 1; pc_enable = 1; step(); clear_strobes();
        check("pc_branch_31", {11'd0, ram_addr}, 16'd31);
        pc_enable = 1; step(); clear_strobes();
        check("pc_wrap", {11'd0, ram_addr}, 16'd0);
        fetch_ir(16'h0111);
        branch = 1; pc_enable = 1; step(); clear_strobes();
        check("pc_branch_17", {11'd0, ram_addr}, 16'd17);
        pc_enable = 1; step(); clear_strobes();
        check("pc_inc_18", {11'd0, ram_addr}, 16'd18);

        // MOVE R3 <- R1 via OR
        load_reg(2'd1, 16'h1234);
        fetch_ir(16'h910D);
        operation = 2'b00; write_reg_enable = 1; step(); clear_strobes();
        read_reg(2'd3, rv);
        check("move_r3", rv, 16'h1234);

        foreach (dec_tab[i]) begin
            fetch_ir(dec_tab[i].ir);
            check($sformatf("decode_%h", dec_tab[i].ir), 16'(decoded_instruction), 16'(dec_tab[i].dec));
        end

        // Reset mid-instruction discards the in-flight write
        load_reg(2'd2, 16'hCAFE);
        fetch_ir(16'h8140);
        data_in = 16'h5A5A; c_sel = 1; write_reg_enable = 1; ir_enable = 1; pc_enable = 1;
        #2 rst_n = 0;
        #1;
        check("midreset_ram_addr", {11'd0, ram_addr}, 16'd0);
        check("midreset_flags", {12'd0, flags_now()}, 16'd0);
        check("midreset_decode", 16'(decoded_instruction), 16'(I_NOP));
        step();
        clear_strobes();
        rst_n = 1;
        step();
        check("post_reset_pc", {11'd0, ram_addr}, 16'd0);
        read_reg(2'd2, rv);
        check("post_reset_r2", rv, 16'h0000);
        read_reg(2'd0, rv);
        check("post_reset_r0", rv, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
